// File: rtl/video_line_buffer.sv
// Ping-pong scanline buffer feeding a 64-entry palette ROM, with two-cycle read latency.
// Optional colour emphasis stage is enabled by defining VIDEO_LINEBUF_EMPHASIS_EN.
module video_line_buffer #(
   parameter int G_line_len     = 256,
   parameter     G_palette_file = "video_palette.hex"
) (
   input  logic       I_clock,
   input  logic       I_reset,
   input  logic       I_wr_valid,
   input  logic [5:0] I_wr_index,
   output logic       O_wr_ready,
   input  logic [2:0] I_emph,
   input  logic       I_rd_line_start,
   input  logic       I_rd_enable,
   output logic [7:0] O_red,
   output logic [7:0] O_green,
   output logic [7:0] O_blue,
   output logic       O_underrun
);

   localparam int                 C_ptr_w = $clog2(G_line_len);
   localparam logic [C_ptr_w-1:0] C_last  = C_ptr_w'(G_line_len - 1);

   // Built-in image of the palette file; only the shipped image is supported.
   localparam logic [23:0] C_palette [64] = '{
      24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
      24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
      24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
      24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
      24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
      24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
   };

   if (G_palette_file != "video_palette.hex") begin : g_palette_check
      $error("video_line_buffer: only the built-in palette image is available");
   end

   logic               wr_bank, rd_bank, pending, rd_valid;
   logic [C_ptr_w-1:0] wr_ptr, rd_ptr;
   logic [5:0]         line_mem [2*G_line_len];
   logic [5:0]         rd_index;
   logic               slot_valid;
   logic [23:0]        rgb;

   logic               wr_accept, wr_last, swap, rd_bank_eff, rd_valid_eff;
   logic [C_ptr_w-1:0] rd_ptr_eff;

`ifdef VIDEO_LINEBUF_EMPHASIS_EN
   logic [2:0] emph_latch [2];
   logic [2:0] slot_emph;

   function automatic logic [7:0] dim(input logic [7:0] c);
      return c - (c >> 2);
   endfunction
`else
   logic unused_emph;
   assign unused_emph = ^I_emph;
`endif

   assign O_wr_ready   = ~pending;
   assign wr_accept    = I_wr_valid & ~pending;
   assign wr_last      = (wr_ptr == C_last);
   assign swap         = I_rd_line_start & pending;
   // A line start in the same cycle as a strobe redirects that read to pixel 0 of the new bank.
   assign rd_bank_eff  = swap ? wr_bank : rd_bank;
   assign rd_ptr_eff   = I_rd_line_start ? '0 : rd_ptr;
   assign rd_valid_eff = rd_valid | swap;

   // NOTE: the line storage has no reset; its contents only matter once a full line is written.
   always_ff @(posedge I_clock) begin
      if (wr_accept)
         line_mem[{wr_bank, wr_ptr}] <= I_wr_index;
      if (I_rd_enable)
         rd_index <= line_mem[{rd_bank_eff, rd_ptr_eff}];
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      rgb = C_palette[rd_index];
`ifdef VIDEO_LINEBUF_EMPHASIS_EN
      if (slot_emph != 3'b000) begin
         if (!slot_emph[0]) rgb[23:16] = dim(rgb[23:16]);
         if (!slot_emph[1]) rgb[15:8]  = dim(rgb[15:8]);
         if (!slot_emph[2]) rgb[7:0]   = dim(rgb[7:0]);
      end
`endif
   end

   always_ff @(posedge I_clock or negedge I_reset) begin
      if (!I_reset) begin
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pending    <= 1'b0;
         rd_valid   <= 1'b0;
         slot_valid <= 1'b0;
         O_underrun <= 1'b0;
         O_red      <= '0;
         O_green    <= '0;
         O_blue     <= '0;
`ifdef VIDEO_LINEBUF_EMPHASIS_EN
         emph_latch[0] <= '0;
         emph_latch[1] <= '0;
         slot_emph     <= '0;
`endif
      end else begin
         O_underrun <= I_rd_line_start & ~pending;

         if (wr_accept) begin
            wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
            if (wr_last) begin
               pending <= 1'b1;
`ifdef VIDEO_LINEBUF_EMPHASIS_EN
               emph_latch[wr_bank] <= I_emph;
`endif
            end
         end

         if (swap) begin
            rd_bank  <= wr_bank;
            wr_bank  <= ~wr_bank;
            pending  <= 1'b0;
            rd_valid <= 1'b1;
         end

         if (I_rd_line_start)
            rd_ptr <= '0;
         if (I_rd_enable)
            rd_ptr <= (rd_ptr_eff == C_last) ? C_last : rd_ptr_eff + 1'b1;

         slot_valid <= I_rd_enable & rd_valid_eff;
`ifdef VIDEO_LINEBUF_EMPHASIS_EN
         if (I_rd_enable)
            slot_emph <= emph_latch[rd_bank_eff];
`endif
         O_red   <= slot_valid ? rgb[23:16] : 8'h00;
         O_green <= slot_valid ? rgb[15:8]  : 8'h00;
         O_blue  <= slot_valid ? rgb[7:0]   : 8'h00;
      end
   end

endmodule
